// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: shared FSM states and memory map constants
package mem_access_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_e;
  localparam int BASE_ADDR = 1024;
  localparam int IDX_BITS = 6;
  localparam int MEM_WORDS = 64;
endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: request bus from EX/MEM plus data memory port
interface mem_access_ctrl_if #(
  parameter int WORD_WIDTH = 32,
  parameter int IDX_BITS = mem_access_ctrl_pkg::IDX_BITS
);
  logic req_rd;
  logic req_wr;
  logic [31:0] req_addr;
  logic [WORD_WIDTH-1:0] req_wdata;
  logic freeze;
  logic ready;
  logic [WORD_WIDTH-1:0] rdata;
  logic addr_err;
  logic [IDX_BITS-1:0] mem_addr;
  logic mem_wr_en;
  logic [WORD_WIDTH-1:0] mem_wr_data;
  logic [WORD_WIDTH-1:0] mem_rd_data;
  modport slave (
    input req_rd, req_wr, req_addr, req_wdata, mem_rd_data,
    output freeze, ready, rdata, addr_err, mem_addr, mem_wr_en, mem_wr_data
  );
  modport master (
    output req_rd, req_wr, req_addr, req_wdata, mem_rd_data,
    input freeze, ready, rdata, addr_err, mem_addr, mem_wr_en, mem_wr_data
  );
endinterface

// File: rtl/mem_access_ctrl_addr_decode.sv
// mem_addr_decode: byte address to word index with range/alignment check
module mem_addr_decode #(
  parameter int BASE_ADDR = mem_access_ctrl_pkg::BASE_ADDR,
  parameter int IDX_BITS = mem_access_ctrl_pkg::IDX_BITS
) (
  input  logic [31:0] addr,
  output logic [IDX_BITS-1:0] idx,
  output logic legal
);
  localparam logic [31:0] BASE = 32'(BASE_ADDR);
  localparam logic [31:0] SPAN = 32'(4 * (2 ** IDX_BITS));
  logic [31:0] off;
  always_comb begin
    off = addr - BASE;
    idx = off[IDX_BITS+1:2];
    legal = (addr >= BASE) && (off < SPAN) && (addr[1:0] == 2'b00);
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences MEM-stage loads/stores over fixed wait cycles
module mem_access_ctrl #(
  parameter int WORD_WIDTH = 32,
  parameter int BASE_ADDR = mem_access_ctrl_pkg::BASE_ADDR,
  parameter int WAIT_CYCLES = 3,
  parameter int IDX_BITS = mem_access_ctrl_pkg::IDX_BITS
) (
  input logic clk,
  input logic rst,
  mem_access_ctrl_if.slave bus
);
  import mem_access_ctrl_pkg::*;
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [IDX_BITS-1:0] idx_q, idx_d, dec_idx;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic wr_q, wr_d, legal, req;
  mem_addr_decode #(.BASE_ADDR(BASE_ADDR), .IDX_BITS(IDX_BITS)) u_dec (
    .addr(bus.req_addr),
    .idx(dec_idx),
    .legal(legal)
  );
  assign req = bus.req_rd | bus.req_wr;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    wdata_d = wdata_q;
    wr_d = wr_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (req) begin
        state_d = legal ? BUSY : ERR;
        if (legal) begin
          idx_d = dec_idx;
          wdata_d = bus.req_wdata;
          wr_d = bus.req_wr;
          cnt_d = 4'(WAIT_CYCLES - 1);
        end
      end
      BUSY: begin
        cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
        state_d = (cnt_q == 4'd0) ? DONE : BUSY;
        rdata_d = (cnt_q == 4'd0 && !wr_q) ? bus.mem_rd_data : rdata_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      wdata_q <= '0;
      wr_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      wdata_q <= wdata_d;
      wr_q <= wr_d;
      rdata_q <= rdata_d;
    end
  end
  assign bus.freeze = (state_q == BUSY) || (state_q == IDLE && req);
  assign bus.ready = (state_q == DONE) || (state_q == ERR);
  assign bus.addr_err = (state_q == ERR);
  assign bus.rdata = rdata_q;
  assign bus.mem_addr = idx_q;
  assign bus.mem_wr_data = wdata_q;
  assign bus.mem_wr_en = (state_q == BUSY) && (cnt_q == 4'd0) && wr_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of access timing, decode and reset abort
module tb_mem_access_ctrl;
  localparam int W = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int wr_cycles[$];
  logic [31:0] mem [64];
  mem_access_ctrl_if bus ();
  mem_access_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wr_data;
  always @(negedge clk) if (bus.mem_wr_en) wr_cycles.push_back(cyc);
  assign bus.mem_rd_data = mem[bus.mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic access(input string tag, input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input bit legal, input logic [5:0] idx,
                        input logic [31:0] exp_rd);
    int last;
    last = legal ? W + 1 : 1;
    @(posedge clk);
    #1;
    bus.req_rd = rd;
    bus.req_wr = wr;
    bus.req_addr = addr;
    bus.req_wdata = data;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      check($sformatf("%s freeze c%0d", tag, c), bus.freeze, c < last);
      check($sformatf("%s ready c%0d", tag, c), bus.ready, c == last);
      check($sformatf("%s addr_err c%0d", tag, c), bus.addr_err, !legal && c == 1);
      check($sformatf("%s wr_en c%0d", tag, c), bus.mem_wr_en, legal && wr && c == W);
      if (legal && c >= 1) check($sformatf("%s mem_addr c%0d", tag, c), bus.mem_addr, idx);
      if (legal && wr && c == W) check($sformatf("%s wr_data", tag), bus.mem_wr_data, data);
      if (c == last && !(legal && wr)) check($sformatf("%s rdata", tag), bus.rdata, exp_rd);
    end
    bus.req_rd = 1'b0;
    bus.req_wr = 1'b0;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    bus.req_rd = 1'b0;
    bus.req_wr = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst freeze", bus.freeze, 0);
    check("rst ready", bus.ready, 0);
    check("rst rdata", bus.rdata, 0);
    check("rst addr_err", bus.addr_err, 0);
    check("rst mem_addr", bus.mem_addr, 0);
    check("rst wr_en", bus.mem_wr_en, 0);
    check("rst wr_data", bus.mem_wr_data, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    access("st1028", 0, 1, 1028, 32'hDEADBEEF, 1, 1, 0);
    check("mem[1]", mem[1], 32'hDEADBEEF);
    access("ld1028", 1, 0, 1028, 0, 1, 1, 32'hDEADBEEF);
    access("st1276", 0, 1, 1276, 32'h1234, 1, 63, 0);
    check("mem[63]", mem[63], 32'h1234);
    n = wr_cycles.size();
    access("rd1280", 1, 0, 1280, 0, 0, 0, 32'hDEADBEEF);
    access("st1020", 0, 1, 1020, 32'h77, 0, 0, 32'hDEADBEEF);
    access("st1030", 0, 1, 1030, 32'h77, 0, 0, 32'hDEADBEEF);
    check("err no writes", wr_cycles.size(), n);
    access("rdwr1032", 1, 1, 1032, 32'h5, 1, 2, 0);
    check("mem[2]", mem[2], 32'h5);
    n = wr_cycles.size();
    access("b2b1024", 0, 1, 1024, 32'hA, 1, 0, 0);
    access("b2b1032", 0, 1, 1032, 32'hB, 1, 2, 0);
    check("b2b pulses", wr_cycles.size(), n + 2);
    if (wr_cycles.size() == n + 2) check("b2b spacing", wr_cycles[n+1] - wr_cycles[n], 5);
    check("mem[0]", mem[0], 32'hA);
    n = wr_cycles.size();
    @(posedge clk);
    #1;
    bus.req_wr = 1'b1;
    bus.req_addr = 1040;
    bus.req_wdata = 32'hCAFE;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.req_wr = 1'b0;
    @(negedge clk);
    check("abort c2 wr_en", bus.mem_wr_en, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort freeze", bus.freeze, 0);
    check("abort rdata", bus.rdata, 0);
    check("abort mem_addr", bus.mem_addr, 0);
    check("abort wr_data", bus.mem_wr_data, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("abort ready %0d", i), bus.ready, 0);
      check($sformatf("abort wr_en %0d", i), bus.mem_wr_en, 0);
      @(negedge clk);
    end
    check("abort no writes", wr_cycles.size(), n);
    check("abort mem[4]", mem[4], 0);
    access("st1040", 0, 1, 1040, 32'hCAFE, 1, 4, 0);
    access("ld1040", 1, 0, 1040, 0, 1, 4, 32'hCAFE);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
